hazard_fwd_unit: RTL

Parametrised hazard and forwarding unit for the pipelined ARM core. It replaces the fixed three-operand, stateless hazard unit. The block keeps its own EX/MEM/WB destination-tag pipeline, so the datapath does not have to feed stage tags back into it. It drives, per source operand:
- the ID-stage operand mux selects;
- load-use stalls and EX bubble insertion;
- PC / IF_ID enables.

It adds two behaviours the previous unit did not have: freezing on a multi-cycle data-memory access, and a flush input.

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_src_cmp.sv | 37 +++
 rtl/hazard_fwd_unit.sv | 76 +++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding unit: stage destination tag and operand select codes.
package hazard_pkg;
  localparam int TAG_RD_W = 8;

  typedef struct packed {
    logic                v;
    logic [TAG_RD_W-1:0] rd;
    logic                rf_en;
    logic                load;
  } stage_tag_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;
endpackage

// File: rtl/hazard_src_cmp.sv
// One ID source operand checked against the EX/MEM/WB tags: operand select and load-use flag.
module hazard_src_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int PC_REG = 15
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  stage_tag_t        i_ex,
  input  stage_tag_t        i_mem,
  input  stage_tag_t        i_wb,
  output logic [1:0]        o_sel,
  output logic              o_load_use
);
  localparam logic [TAG_RD_W-1:0] PC_IDX = TAG_RD_W'(PC_REG);

  logic [TAG_RD_W-1:0] w_src;
  logic w_live, w_ex_hit, w_mem_hit, w_wb_hit;

  assign w_src  = TAG_RD_W'(i_src);
  // The PC always reads its live value, so it never takes a bypass path.
  assign w_live = i_use & (w_src != PC_IDX);

  assign w_ex_hit  = w_live & i_ex.v  & i_ex.rf_en  & (i_ex.rd  == w_src);
  assign w_mem_hit = w_live & i_mem.v & i_mem.rf_en & (i_mem.rd == w_src);
  assign w_wb_hit  = w_live & i_wb.v  & i_wb.rf_en  & (i_wb.rd  == w_src);

  always_comb begin
    o_sel = SEL_RF;
    if (w_ex_hit)       o_sel = SEL_EX;
    else if (w_mem_hit) o_sel = SEL_MEM;
    else if (w_wb_hit)  o_sel = SEL_WB;
  end

  assign o_load_use = w_ex_hit & i_ex.load;
endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit with its own EX/MEM/WB tag pipeline, mem_busy freeze and flush.
// Optional stall performance counter: define HAZARD_PERF_CNT_EN.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int REG_AW  = 4,
  parameter int PC_REG  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_rf_en,
  input  logic                      id_load,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_use,
  input  logic                      flush,
  input  logic                      mem_busy,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      nop_ex,
  output logic [15:0]               stall_cnt
);
  stage_tag_t r_ex, r_mem, r_wb;
  stage_tag_t w_id_tag;
  logic [NUM_SRC-1:0] w_lu;
  logic w_load_use;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_src_cmp #(.REG_AW(REG_AW), .PC_REG(PC_REG)) u_cmp (
      .i_src      (id_src[g*REG_AW +: REG_AW]),
      .i_use      (id_src_use[g]),
      .i_ex       (r_ex),
      .i_mem      (r_mem),
      .i_wb       (r_wb),
      .o_sel      (fwd_sel[2*g +: 2]),
      .o_load_use (w_lu[g])
    );
  end

  assign w_load_use = id_valid & (|w_lu);
  // A squashed instruction must not hold up fetch of the branch target.
  assign stall      = mem_busy | (w_load_use & ~flush);
  assign pc_en      = ~stall;
  assign if_id_en   = ~stall;
  assign nop_ex     = ~mem_busy & (w_load_use | flush | ~id_valid);

  assign w_id_tag = '{v: id_valid, rd: TAG_RD_W'(id_rd), rf_en: id_rf_en, load: id_load};

  // The whole tag pipe freezes while data memory is busy, so selects stay stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= nop_ex ? '0 : w_id_tag;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             r_stall_cnt <= '0;
    else if (stall && r_stall_cnt != '1)    r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule
